// File: rtl/dp_seq_pkg.sv
// Shared definitions for the datapath program sequencer: opcodes, instruction
// field positions, FSM state encoding and the arithmetic-op qualifier.
package dp_seq_pkg;

  localparam int unsigned INSTR_W = 15;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned REG_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
  localparam logic [OP_W-1:0] OP_COPY  = 3'b001;
  localparam logic [OP_W-1:0] OP_LOAD1 = 3'b010;
  localparam logic [OP_W-1:0] OP_LOAD2 = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b110;
  localparam logic [OP_W-1:0] OP_MUL   = 3'b111;

  localparam int unsigned OP_MSB   = 14;
  localparam int unsigned OP_LSB   = 12;
  localparam int unsigned DEST_MSB = 11;
  localparam int unsigned DEST_LSB = 8;
  localparam int unsigned SRC1_MSB = 7;
  localparam int unsigned SRC1_LSB = 4;
  localparam int unsigned SRC2_MSB = 3;
  localparam int unsigned SRC2_LSB = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Only these ops can raise a meaningful datapath overflow.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// Program-load handshake plus the instruction/overflow link to the datapath.
// The master side offers program words and hosts the datapath; the slave is the sequencer.
interface datapath_sequencer_if;
  import dp_seq_pkg::*;

  logic               load_valid;
  logic               load_ready;
  logic [INSTR_W-1:0] load_instr;

  logic [OP_W-1:0]    dp_op;
  logic [REG_W-1:0]   dp_src1;
  logic [REG_W-1:0]   dp_src2;
  logic [REG_W-1:0]   dp_dest;
  logic               dp_overflow;

  modport master (
    output load_valid, load_instr, dp_overflow,
    input  load_ready, dp_op, dp_src1, dp_src2, dp_dest
  );

  modport slave (
    input  load_valid, load_instr, dp_overflow,
    output load_ready, dp_op, dp_src1, dp_src2, dp_dest
  );

endinterface

// File: rtl/datapath_sequencer_prog_mem.sv
// Program buffer: DEPTH x INSTR_W register array, one synchronous write port
// and one asynchronous read port. Contents are intentionally not reset.
module dp_prog_mem
  import dp_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/datapath_sequencer.sv
// Program sequencer for the 16x17 register-file/ALU datapath: buffers a short
// program, issues one instruction per cycle, and tracks overflow and progress.
// Optional build macro DP_SEQ_HALT_ON_OVF_EN ends a run at the first overflow.
module datapath_sequencer
  import dp_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  datapath_sequencer_if.slave      bus,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   prog_len,
  output logic                     ovf_sticky,
  output logic [$clog2(DEPTH)-1:0] ovf_pc,
  output logic [CW-1:0]            issue_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_t             state;
  logic [LW-1:0]      wr_ptr;
  logic [AW-1:0]      pc;
  logic [INSTR_W-1:0] rd_instr;
  logic               load_fire;
  logic               ovf_hit;
  logic               last_instr;
  logic               finish;

  assign bus.load_ready = (state == IDLE) && (wr_ptr < LW'(DEPTH)) && !start && !clear;
  assign load_fire      = bus.load_valid && bus.load_ready;
  assign prog_len       = wr_ptr;
  assign busy           = (state == RUN);

  dp_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (load_fire),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.load_instr),
    .raddr (pc),
    .rdata (rd_instr)
  );

  // Datapath drive; abort suppresses the op so nothing is written that cycle.
  always_comb begin
    bus.dp_op   = OP_NOP;
    bus.dp_dest = '0;
    bus.dp_src1 = '0;
    bus.dp_src2 = '0;
    if (state == RUN) begin
      bus.dp_dest = rd_instr[DEST_MSB:DEST_LSB];
      bus.dp_src1 = rd_instr[SRC1_MSB:SRC1_LSB];
      bus.dp_src2 = rd_instr[SRC2_MSB:SRC2_LSB];
      if (!abort) bus.dp_op = rd_instr[OP_MSB:OP_LSB];
    end
  end

  assign ovf_hit    = (state == RUN) && bus.dp_overflow && is_arith(bus.dp_op);
  assign last_instr = (LW'(pc) == (wr_ptr - LW'(1)));

`ifdef DP_SEQ_HALT_ON_OVF_EN
  assign finish = last_instr || ovf_hit;
`else
  assign finish = last_instr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      pc         <= '0;
      done       <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_pc     <= '0;
      issue_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // clear has priority over start; loads only happen when neither is asserted
          if (clear) begin
            wr_ptr <= '0;
          end else if (start) begin
            pc         <= '0;
            ovf_sticky <= 1'b0;
            ovf_pc     <= '0;
            issue_cnt  <= '0;
            if (wr_ptr != '0) state <= RUN;
            else              done  <= 1'b1;
          end else if (load_fire) begin
            wr_ptr <= wr_ptr + LW'(1);
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            pc    <= '0;
          end else begin
            if (issue_cnt != '1) issue_cnt <= issue_cnt + CW'(1);
            if (ovf_hit) begin
              ovf_sticky <= 1'b1;
              if (!ovf_sticky) ovf_pc <= pc;
            end
            if (finish) begin
              state <= IDLE;
              done  <= 1'b1;
              pc    <= '0;
            end else begin
              pc <= pc + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Program sequencer for the 16x17 register-file/ALU datapath.
- Buffers a short program of datapath instructions loaded over a valid/ready port.
- On start, issues one instruction per cycle on the datapath's op/src1/src2/dest inputs.
- Samples the datapath overflow flag and reports it as a sticky flag with the first offending PC, plus done and status outputs.

Parameters:
- DEPTH, 16, number of instruction slots in the program buffer; power of two, 2..64.
- CW, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  instruction word offered.
- load_ready  out  1  sequencer accepts the word this cycle.
- load_instr  in  15  {op[14:12], dest[11:8], src1[7:4], src2[3:0]}.
- clear  in  1  empty the program buffer (IDLE only).
- start  in  1  run the loaded program from slot 0.
- abort  in  1  stop a running program.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the program completes.
- prog_len  out  $clog2(DEPTH)+1  number of loaded instructions.
- dp_op  out  3  to datapath op.
- dp_src1  out  4  to datapath src1.
- dp_src2  out  4  to datapath src2.
- dp_dest  out  4  to datapath dest.
- dp_overflow  in  1  from datapath overflow.
- ovf_sticky  out  1  an arithmetic overflow occurred since the last start.
- ovf_pc  out  $clog2(DEPTH)  PC of the first overflowing instruction.
- issue_cnt  out  CW  instructions issued since the last start; saturates at all-ones.

Behaviour:
- States: IDLE, RUN.
- Reset values: state IDLE, wr_ptr 0, pc 0, done 0, ovf_sticky 0, ovf_pc 0, issue_cnt 0. Buffer contents are not reset.
- load_ready = IDLE and wr_ptr<DEPTH and not start and not clear.
  - Handshake: on load_valid and load_ready, write mem[wr_ptr] and increment wr_ptr.
  - prog_len = wr_ptr.
  - When full, load_ready is low and words are not accepted.
- clear in IDLE: wr_ptr<=0. clear in RUN is ignored. clear together with start: clear wins, start is ignored.
- start in IDLE with prog_len>0:
  - pc<=0, ovf_sticky<=0, ovf_pc<=0, issue_cnt<=0, state<=RUN.
  - start in RUN is ignored.
- start in IDLE with prog_len==0: counters and flags clear, done pulses the next cycle, state stays IDLE.
- Datapath drive (combinational from state/pc):
  - In IDLE: dp_op=000 (NOP), dp_src*/dp_dest=0.
  - In RUN: dp_* = fields of mem[pc].
  - The datapath executes the instruction and writes its register file at the same clock edge, so issue latency is 1 instruction per cycle with no bubbles.
  - The first instruction is visible the cycle after start.
- Each RUN cycle without abort: issue_cnt increments (saturating).
  - If pc==prog_len-1: state<=IDLE, done<=1 for exactly one cycle, pc<=0.
  - Otherwise pc<=pc+1.
- Overflow qualification: ovf_hit = RUN and dp_overflow and dp_op in {100 ADD, 110 SUB, 111 MUL}. dp_overflow during any other op is ignored.
  - On ovf_hit: ovf_sticky<=1.
  - ovf_pc<=pc only if ovf_sticky was 0, so the first hit is kept.
- abort in RUN:
  - dp_op is forced to 000 that cycle, so the datapath does not write.
  - Next state is IDLE, no done pulse, issue_cnt not incremented.
  - abort in IDLE has no effect.
- Op 101 is passed through unchanged; the datapath treats it as a no-write.
- The buffer is retained after a run; start replays the same program.
- Asynchronous reset mid-RUN returns to IDLE immediately, with dp_op=NOP from the reset assertion.

Optional Feature:
- Macro DP_SEQ_HALT_ON_OVF_EN.
- Defined: an ovf_hit ends the run after that instruction.
  - The overflowing result is still written.
  - state<=IDLE, done pulses, pc<=0.
  - The remaining instructions are not issued.
- Undefined: overflow is recorded only and the run continues to prog_len.

Decomposition:
- Package dp_seq_pkg holds:
  - opcode localparams OP_NOP/COPY/LOAD1/LOAD2/ADD/SUB/MUL;
  - instruction field positions (OP_MSB..SRC2_LSB);
  - the state encoding (IDLE=0, RUN=1);
  - an is_arith() function.
- One sub-module, dp_prog_mem:
  - DEPTH x 15 register array;
  - one synchronous write port, one asynchronous read port;
  - no reset.

Test Plan:
- Load ADD r3,r1,r2 then SUB r4,r3,r1 (prog_len=2), pulse start -> busy for 2 cycles; dp_op=100 then 110 with correct fields; done pulses once; issue_cnt=2.
- Load DEPTH words, offer one more -> load_ready low on the extra word; prog_len=16; the extra word is not stored.
- Program {LOAD1 r1, LOAD1 r2, MUL r5,r1,r2, NOP} with ext_data1=17'h1FFFF so MUL overflows -> ovf_sticky=1, ovf_pc=2. With DP_SEQ_HALT_ON_OVF_EN: done at pc 2, issue_cnt=3. Without it: issue_cnt=4.
- 4-instruction program, abort asserted while pc==1 -> dp_op=000 that cycle; next cycle IDLE; no done; issue_cnt=1.
- start with prog_len=0 -> done pulses one cycle later; busy never high. clear and start together in IDLE -> prog_len=0, no run.
- Assert rst_n low mid-RUN -> busy=0, dp_op=000, ovf_sticky=0, prog_len=0 immediately; after release, load/start works normally.
